alu_seq: RTL

Parametrised multi-cycle integer execution unit, successor to the single-cycle combinational ALU in the execute stage.
- Single-cycle ops (logic, add/sub, compare, shift, LUI) finish with 1-cycle registered latency.
- MUL/MULU run an iterative shift-add multiplier; DIV/DIVU run an iterative restoring divider. Both produce a full 2*WIDTH result split across result/hi.
- A start/ready/done handshake lets the pipeline controller stall the execute stage while a multi-cycle op runs.

---
 rtl/alu_seq.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// Multi-cycle integer execution unit: registered single-cycle ALU ops plus
// iterative shift-add multiply and restoring divide with a start/ready/done handshake.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_zero
);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOR  = 4'd5,  OP_SLT = 4'd6,  OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8,  OP_SRL  = 4'd9,  OP_SRA = 4'd10, OP_LUI  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12, OP_MULU = 4'd13, OP_DIV = 4'd14, OP_DIVU = 4'd15;

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_RESP} state_t;

  state_t state, state_nx;

  logic                 accept, is_mul, is_div, signed_op, b_zero, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag, simple_res;
  logic [2*WIDTH-1:0]   acc, mul_nx, div_nx, prod_fix;
  logic [WIDTH-1:0]     opnd, quo_fix, rem_fix, fix_lo, fix_hi, div_diff;
  logic [WIDTH:0]       mul_sum, div_r;
  logic                 div_ge;
  logic [SHW-1:0]       cnt;
  logic                 neg_lo, neg_hi, fix_div;

  function automatic logic [WIDTH-1:0] alu_simple(input logic [3:0] f,
                                                  input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y,
                                                  input logic [SHW-1:0] s);
    case (f)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_OR:   return x | y;
      OP_XOR:  return x ^ y;
      OP_NOR:  return ~(x | y);
      OP_SLT:  return WIDTH'($signed(x) < $signed(y));
      OP_SLTU: return WIDTH'(x < y);
      OP_SLL:  return y << s;
      OP_SRL:  return y >> s;
      OP_SRA:  return $signed(y) >>> s;
      OP_LUI:  return y << (WIDTH / 2);
      default: return '0;
    endcase
  endfunction

  assign is_mul     = (op == OP_MUL) || (op == OP_MULU);
  assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
  assign signed_op  = (op == OP_MUL) || (op == OP_DIV);
  assign b_zero     = is_div && (b == '0);
  assign a_neg      = signed_op && a[WIDTH-1];
  assign b_neg      = signed_op && b[WIDTH-1];
  assign a_mag      = a_neg ? -a : a;
  assign b_mag      = b_neg ? -b : b;
  assign simple_res = alu_simple(op, a, b, shamt);
  assign accept     = start && ready;

  // Shift-add step: acc = {partial product, remaining multiplier bits}
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // Restoring step: acc = {partial remainder, dividend bits becoming quotient}
  assign div_r    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge   = div_r >= {1'b0, opnd};
  assign div_diff = div_r[WIDTH-1:0] - opnd;
  assign div_nx   = {div_ge ? div_diff : div_r[WIDTH-1:0], acc[WIDTH-2:0], div_ge};

  assign prod_fix = neg_lo ? -acc : acc;
  assign quo_fix  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign fix_lo   = fix_div ? quo_fix : prod_fix[WIDTH-1:0];
  assign fix_hi   = fix_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (is_mul)                 state_nx = S_MUL;
          else if (is_div && !b_zero) state_nx = S_DIV;
          else                        state_nx = S_RESP;
        end
      end
      S_MUL, S_DIV: begin
        if (abort)                          state_nx = S_IDLE;
        else if (cnt == SHW'(WIDTH - 1))    state_nx = S_FIX;
      end
      S_FIX:   state_nx = abort ? S_IDLE : S_RESP;
      S_RESP: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      fix_div  <= 1'b0;
      result   <= '0;
      hi       <= '0;
      zero     <= 1'b1;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          cnt      <= '0;
          div_zero <= b_zero;
          acc      <= {{WIDTH{1'b0}}, a_mag};
          opnd     <= b_mag;
          neg_lo   <= a_neg ^ b_neg;
          neg_hi   <= is_div ? a_neg : (a_neg ^ b_neg);
          fix_div  <= is_div;
          // Multi-cycle ops leave the visible outputs alone until FIX
          if (b_zero) begin
            result <= '1;
            hi     <= a;
            zero   <= 1'b0;
          end else if (!is_mul && !is_div) begin
            result <= simple_res;
            hi     <= '0;
            zero   <= (simple_res == '0);
          end
        end
        S_MUL: if (!abort) begin
          acc <= mul_nx;
          cnt <= cnt + SHW'(1);
        end
        S_DIV: if (!abort) begin
          acc <= div_nx;
          cnt <= cnt + SHW'(1);
        end
        S_FIX: if (!abort) begin
          result <= fix_lo;
          hi     <= fix_hi;
          zero   <= (fix_lo == '0);
        end
        default: ;
      endcase
    end
  end

endmodule
